// File: rtl/frog_player_array.sv
// Frog player for a pixel-grid crossing game: button-edge movement, hazard collisions
// with a blinking invulnerable period, goal scoring, lives and game-over handling.
module frog_player_array #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int START_ROW  = ROWS - 1,
    parameter int START_COL  = 11,
    parameter int LIVES      = 3,
    parameter int HIT_CYCLES = 8,
    parameter int SCORE_W    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       up,
    input  logic                       down,
    input  logic                       left,
    input  logic                       right,
    input  logic [ROWS-1:0][COLS-1:0]  RedPixels,
    output logic [ROWS-1:0][COLS-1:0]  GrnPixels,
    output logic                       win,
    output logic [SCORE_W-1:0]         score,
    output logic [2:0]                 lives,
    output logic                       game_over
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    // The blink reads counter bit 1, so the counter is never narrower than two bits.
    localparam int CNT_W = (HIT_CYCLES > 4) ? $clog2(HIT_CYCLES) : 2;

    localparam logic [ROW_W-1:0]   ROW_MAX    = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]   COL_MAX    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   SPAWN_ROW  = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0]   SPAWN_COL  = COL_W'(START_COL);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [CNT_W-1:0]   HIT_LAST   = CNT_W'(HIT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_HIT  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [2:0]         r_lives;
    logic [SCORE_W-1:0] r_score;
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [3:0]         r_btn_prev;
    logic               r_win;

    logic [3:0]         w_btn;
    logic [3:0]         w_edge;
    logic               w_move;
    logic               w_hazard;
    logic               w_visible;
    logic [ROW_W-1:0]   w_next_row;
    logic [COL_W-1:0]   w_next_col;

    // Button order {up, down, left, right}; only a lone rising edge is a move request.
    assign w_btn    = {up, down, left, right};
    assign w_edge   = w_btn & ~r_btn_prev;
    assign w_move   = $onehot(w_edge);
    assign w_hazard = RedPixels[r_row][r_col];

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_next_row = r_row;
        w_next_col = r_col;
        if (w_move) begin
            if (w_edge[3] && (r_row != '0))     w_next_row = r_row - 1'b1;
            if (w_edge[2] && (r_row != ROW_MAX)) w_next_row = r_row + 1'b1;
            if (w_edge[1] && (r_col != COL_MAX)) w_next_col = r_col + 1'b1;
            if (w_edge[0] && (r_col != '0))     w_next_col = r_col - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_row      <= SPAWN_ROW;
            r_col      <= SPAWN_COL;
            r_lives    <= LIVES_INIT;
            r_score    <= '0;
            r_state    <= ST_PLAY;
            r_hit_cnt  <= '0;
            r_win      <= 1'b0;
            r_btn_prev <= w_btn;
        end else begin
            r_btn_prev <= w_btn;
            r_win      <= 1'b0;
            if (enable) begin
                case (r_state)
                    ST_PLAY: begin
                        if (w_hazard) begin
                            r_row     <= SPAWN_ROW;
                            r_col     <= SPAWN_COL;
                            r_lives   <= r_lives - 1'b1;
                            r_hit_cnt <= '0;
                            r_state   <= (r_lives > 3'd1) ? ST_HIT : ST_OVER;
                        end else if (r_row == '0) begin
                            r_row   <= SPAWN_ROW;
                            r_col   <= SPAWN_COL;
                            r_win   <= 1'b1;
                            if (r_score != SCORE_MAX) r_score <= r_score + 1'b1;
                        end else begin
                            r_row <= w_next_row;
                            r_col <= w_next_col;
                        end
                    end
                    ST_HIT: begin
                        if (r_hit_cnt == HIT_LAST) begin
                            r_hit_cnt <= '0;
                            r_state   <= ST_PLAY;
                        end else begin
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        // OVER holds everything until reset.
                    end
                endcase
            end
        end
    end

    assign w_visible = enable && ((r_state != ST_HIT) || !r_hit_cnt[1]);

    always_comb begin
        GrnPixels = '0;
        if (w_visible) GrnPixels[r_row][r_col] = 1'b1;
    end

    assign win       = r_win;
    assign score     = r_score;
    assign lives     = r_lives;
    assign game_over = (r_state == ST_OVER);

endmodule

// File: tb/tb_frog_player_array.sv
// Directed self-checking bench for frog_player_array with default parameters.
module tb_frog_player_array;

    logic                 clock;
    logic                 reset;
    logic                 enable;
    logic                 up, down, left, right;
    logic [15:0][15:0]    RedPixels;
    logic [15:0][15:0]    GrnPixels;
    logic                 win;
    logic [3:0]           score;
    logic [2:0]           lives;
    logic                 game_over;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    frog_player_array dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .RedPixels (RedPixels),
        .GrnPixels (GrnPixels),
        .win       (win),
        .score     (score),
        .lives     (lives),
        .game_over (game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [255:0] frog_map(input int row, input int col);
        logic [15:0][15:0] m;
        m = '0;
        m[row][col] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // One press then one release of the buttons in mask {up, down, left, right}.
    task automatic press(input logic [3:0] mask);
        {up, down, left, right} = mask;
        tick();
        {up, down, left, right} = 4'b0000;
        tick();
    endtask

    logic vis [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        reset = 1'b1; enable = 1'b1;
        {up, down, left, right} = 4'b0000;
        RedPixels = '0;
        tick();
        reset = 1'b0;

        chk("reset_map",   256'(GrnPixels), frog_map(15, 11));
        chk("reset_lives", 256'(lives), 256'(3));
        chk("reset_score", 256'(score), 256'(0));
        chk("reset_win",   256'(win), 256'(0));
        chk("reset_over",  256'(game_over), 256'(0));

        // Single up step, then holding up gives no further steps.
        up = 1'b1;
        tick();
        chk("up_one_step", 256'(GrnPixels), frog_map(14, 11));
        for (int i = 0; i < 4; i++) tick();
        chk("up_held", 256'(GrnPixels), frog_map(14, 11));
        up = 1'b0;
        tick();

        // Boundaries: down clamps at row 15, right clamps at col 0, two edges ignored.
        press(4'b0100);
        chk("down_to_15", 256'(GrnPixels), frog_map(15, 11));
        press(4'b0100);
        chk("down_clamp", 256'(GrnPixels), frog_map(15, 11));
        for (int i = 0; i < 11; i++) press(4'b0001);
        chk("right_to_0", 256'(GrnPixels), frog_map(15, 0));
        press(4'b0001);
        chk("right_clamp", 256'(GrnPixels), frog_map(15, 0));
        press(4'b1010);
        chk("up_left_ignored", 256'(GrnPixels), frog_map(15, 0));
        press(4'b0010);
        chk("left_step", 256'(GrnPixels), frog_map(15, 1));

        // Reset with up held: back to spawn, and the held button does not step.
        reset = 1'b1; up = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("reset_held_up", 256'(GrnPixels), frog_map(15, 11));
        up = 1'b0;
        tick();

        // Walk to the goal row.
        for (int i = 0; i < 14; i++) press(4'b1000);
        chk("row_1", 256'(GrnPixels), frog_map(1, 11));
        up = 1'b1;
        tick();
        chk("row_0", 256'(GrnPixels), frog_map(0, 11));
        chk("no_win_yet", 256'(win), 256'(0));
        up = 1'b0;
        tick();
        chk("win_pulse", 256'(win), 256'(1));
        chk("score_1", 256'(score), 256'(1));
        chk("goal_respawn", 256'(GrnPixels), frog_map(15, 11));
        tick();
        chk("win_one_cycle", 256'(win), 256'(0));

        // Collision at spawn, blink through HIT, ups ignored, hazard ignored.
        RedPixels[15][11] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("blink_%0d", i), 256'(GrnPixels), vis[i] ? frog_map(15, 11) : 256'(0));
            if (i == 0) chk("hit_lives", 256'(lives), 256'(2));
            if (i == 1) up = 1'b1;
            if (i == 3) up = 1'b0;
        end
        tick();
        chk("hit_done_map", 256'(GrnPixels), frog_map(15, 11));
        chk("hit_done_lives", 256'(lives), 256'(2));
        chk("hit_done_over", 256'(game_over), 256'(0));

        // Two more collisions with the hazard left in place lead to OVER.
        for (int i = 0; i < 10; i++) tick();
        chk("over_lives", 256'(lives), 256'(0));
        chk("over_flag", 256'(game_over), 256'(1));
        chk("over_map", 256'(GrnPixels), frog_map(15, 11));
        RedPixels = '0;
        press(4'b1000);
        chk("over_ignore", 256'(GrnPixels), frog_map(15, 11));
        chk("over_score", 256'(score), 256'(1));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_over_lives", 256'(lives), 256'(3));
        chk("rst_over_flag", 256'(game_over), 256'(0));
        chk("rst_over_score", 256'(score), 256'(0));

        // Disabled: hidden and frozen, reappears at the same cell.
        enable = 1'b0;
        #1;
        chk("disable_hidden", 256'(GrnPixels), 256'(0));
        press(4'b1000);
        chk("disable_no_move", 256'(GrnPixels), 256'(0));
        enable = 1'b1;
        #1;
        chk("reenable_map", 256'(GrnPixels), frog_map(15, 11));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frog_player_array.md
FROG_PLAYER_ARRAY -- requirements
Module: frog_player_array

Interface
REQ-001 Parameter ROWS, 16, number of pixel-grid rows; row index 0 is the goal row.
REQ-002 Parameter COLS, 16, number of pixel-grid columns.
REQ-003 Parameter START_ROW, ROWS-1, spawn row.
REQ-004 Parameter START_COL, 11, spawn column.
REQ-005 Parameter LIVES, 3, lives at reset (1..7).
REQ-006 Parameter HIT_CYCLES, 8, length of post-collision invulnerable period in clocks (>=2).
REQ-007 Parameter SCORE_W, 4, score counter width.
REQ-008 clock  input  1  system clock; one clock domain; all state on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 enable  input  1  1 = frog active and displayed; 0 = frozen and hidden.
REQ-011 up, down, left, right  input  1 each  level button inputs, synchronous to clock.
REQ-012 RedPixels  input  [ROWS-1:0][COLS-1:0]  hazard map, 1 = hazard.
REQ-013 GrnPixels  output  [ROWS-1:0][COLS-1:0]  frog display, at most one bit set.
REQ-014 win  output  1  one-cycle pulse per goal reached.
REQ-015 score  output  SCORE_W  goals reached, saturating.
REQ-016 lives  output  3  lives remaining.
REQ-017 game_over  output  1  high in OVER state.

Function
REQ-018 Registered state: row, col, lives, score, state (PLAY, HIT, OVER), hit counter, previous-sample register per button.
REQ-019 Move request: rising edge (current 1, previous 0) on exactly one button; two or more simultaneous edges ignored; a held button produces one step only.
REQ-020 Move direction: up row-1, down row+1, left col+1, right col-1; clamp at 0, ROWS-1, COLS-1; no wrap-around.
REQ-021 Button previous-sample registers update every cycle regardless of state or enable.
REQ-022 PLAY, per cycle with enable=1, priority: collision > goal > move.
REQ-023 Collision: RedPixels[row][col]==1 at current position -> next cycle lives-1, row/col to spawn; state HIT if lives was >1, else OVER with lives=0; move request that cycle discarded.
REQ-024 Goal: row==0 with no collision -> win=1 next cycle for exactly one cycle, score+1 (holds at 2^SCORE_W-1), row/col to spawn, stay PLAY.
REQ-025 HIT: moves, collisions, goals ignored; counter runs 0..HIT_CYCLES-1 then state PLAY; frog displayed only when counter bit 1 is 0 (blink).
REQ-026 OVER: game_over=1, frog displayed at spawn, all inputs ignored until reset.
REQ-027 enable=0: GrnPixels all zero, state/position/counters hold, no win pulses.
REQ-028 GrnPixels combinational from registers: single bit at [row][col] when enable=1 and (state != HIT or blink visible).
REQ-029 lives and score change only at collision/goal events; win never asserted in HIT or OVER.

Reset
REQ-030 On reset=1 at a clock edge: row=START_ROW, col=START_COL, lives=LIVES, score=0, state PLAY, hit counter 0, win=0, game_over=0, button registers loaded with current inputs (held buttons do not move after reset).
REQ-031 Reset overrides every other event in the same cycle, including mid-HIT and OVER.

Verification
REQ-032 Default params, reset, single up pulse -> row 15->14 after one edge; up held 5 cycles -> one step only.
REQ-033 From spawn, 15 up presses on empty hazard map -> at row 0, win pulses one cycle, score=1, frog back at (15,11).
REQ-034 Hazard at frog cell -> lives 3->2, frog at spawn, blink pattern for 8 cycles, hazard ignored during HIT, then PLAY.
REQ-035 Three collisions -> lives=0, game_over=1, presses ignored; reset -> lives=3, game_over=0.
REQ-036 right pressed at col 0 and down at row 15 -> position unchanged; up+left same cycle -> no move.
REQ-037 enable=0 during up press -> GrnPixels all zero, no move; enable=1 -> frog reappears at prior cell.
